// File: rtl/alu_src_sel_buf.sv
// ALU operand-B source selector feeding a small FIFO with a valid/ready handshake
// on the ALU side, plus a sticky flag for out-of-range source selects.
module alu_src_sel_buf #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         count,
  output logic                     sel_err,
  input  logic                     err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (NUM_SRC > 2**SEL_W) begin : gSelTooNarrow
      $error("alu_src_sel_buf: SEL_W too narrow for NUM_SRC");
    end
    if (NUM_SRC < 2 || NUM_SRC > 16) begin : gBadNumSrc
      $error("alu_src_sel_buf: NUM_SRC must be 2..16");
    end
    if (DEPTH < 1 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
      $error("alu_src_sel_buf: DEPTH must be a power of two in 1..16");
    end
    if ((2**CNT_W) <= DEPTH) begin : gBadCntW
      $error("alu_src_sel_buf: CNT_W cannot hold DEPTH");
    end
  endgenerate

  // Out-of-range selects fall through the loop and yield all-zeros.
  function automatic logic [WIDTH-1:0] selectSrc(input logic [NUM_SRC*WIDTH-1:0] srcs,
                                                 input logic [SEL_W-1:0]         idx);
    logic [WIDTH-1:0] word;
    word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(idx) == k) word = srcs[k*WIDTH +: WIDTH];
    end
    return word;
  endfunction

  // Power-of-two depth lets the pointer wrap by overflow; a single entry pins it at 0.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             push;
  logic             pop;
  logic             selOutOfRange;

  assign selOutOfRange = (int'(sel) >= NUM_SRC);
  assign in_ready      = (count != CNT_W'(DEPTH));
  assign out_valid     = (count != '0);
  assign push          = in_valid && in_ready;
  assign pop           = out_valid && out_ready;
  assign out_data      = out_valid ? mem[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= selectSrc(src_flat, sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      sel_err <= 1'b0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A bad push in the same cycle as a clear keeps the flag raised.
      if (push && selOutOfRange) sel_err <= 1'b1;
      else if (err_clr)          sel_err <= 1'b0;
    end
  end

endmodule

// File: doc/alu_src_sel_buf.md
Name: alu_src_sel_buf

Overview:
- Parametrised successor to the single-cycle ALU operand-B selector.
- Selects one of NUM_SRC operand sources per transaction and captures the selected word into a DEPTH-entry FIFO.
- Delivers operands to the ALU over a valid/ready handshake, so the ALU-side state machine can stall without losing operands.
- Flags out-of-range selects with a sticky error bit.

Parameters:
WIDTH, 32, operand width in bits
NUM_SRC, 4, number of selectable sources (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC
DEPTH, 2, FIFO entries; power of two, 1..16
CNT_W, 2, occupancy counter width; must hold the value DEPTH (DEPTH=1 -> 1, 2..3 -> 2, 4..7 -> 3, 8..15 -> 4, 16 -> 5)

Ports:
clk  in  1  rising-edge clock; the only clock
reset  in  1  asynchronous, active-high reset
src_flat  in  NUM_SRC*WIDTH  source k occupies bits [k*WIDTH +: WIDTH]
sel  in  SEL_W  source index for the current input transaction
in_valid  in  1  producer offers sel/src_flat this cycle
in_ready  out  1  block can accept this cycle
out_data  out  WIDTH  operand at FIFO head
out_valid  out  1  out_data is valid
out_ready  in  1  ALU consumes head this cycle
count  out  CNT_W  entries currently held
sel_err  out  1  sticky: an accepted transaction had sel >= NUM_SRC
err_clr  in  1  synchronous clear of sel_err

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, wr_ptr=0, rd_ptr=0, sel_err=0.
  - out_valid=0, in_ready=1.
  - Storage contents are don't-care.
  - out_data is don't-care while out_valid=0, but must not be X-propagating (drive 0 when empty).
- Push: occurs on a rising edge when in_valid && in_ready.
  - Stores src_flat[sel*WIDTH +: WIDTH] at wr_ptr.
  - If sel >= NUM_SRC, stores all-zeros and sets sel_err.
  - sel and src_flat are sampled only at the push edge.
- Pop: occurs on a rising edge when out_valid && out_ready. Advances rd_ptr.
- Flags:
  - in_ready = (count != DEPTH), registered-state only.
  - in_ready never depends combinationally on out_ready.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
- Latency: an entry pushed at edge N is visible on out_data/out_valid after edge N. There is no same-cycle bypass from input to output.
- Simultaneous push and pop (count between 1 and DEPTH-1): both take effect; count unchanged.
- Empty: pop impossible (out_valid=0). out_ready is ignored.
- Full: push impossible (in_ready=0) even if out_ready=1 that cycle. That pop still occurs, and in_ready rises the next cycle.
- Pointers: wr_ptr and rd_ptr wrap modulo DEPTH. For DEPTH=1 the pointers are constant 0.
- Ordering: strict FIFO. The ALU sees operands in acceptance order.
- sel_err:
  - Sets on an accepted out-of-range push.
  - Clears on err_clr.
  - If set and clear coincide, set wins.
  - Transactions not accepted (in_ready=0) never set it.
- count holds values 0..DEPTH.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Synthesis-time check: NUM_SRC > 2**SEL_W is an elaboration error.

Test Plan:
- Reset, then src0..3 = 0x11111111, 0x00000004, 0xFFFF8000, 0x00020000; push sel=0,1,2,3 with out_ready=1 -> out_data 0x11111111, 0x00000004, 0xFFFF8000, 0x00020000 each one cycle after its push; count never exceeds 1; sel_err=0.
- DEPTH=2, out_ready=0: push sel=1 then sel=3 -> count=2, in_ready=0. A third offer with sel=0 is not accepted. Raise out_ready for 2 cycles -> 0x00000004 then 0x00020000 pops; in_ready=1 the cycle after the first pop.
- Full FIFO with in_valid=1 and out_ready=1 on the same cycle -> pop only, count 2->1, no push; next cycle push accepted.
- Count=1 with simultaneous push (sel=2) and pop -> count stays 1; next head=0xFFFF8000; run 10 push/pop pairs to verify pointer wrap and preserved order.
- NUM_SRC=3, SEL_W=2, push sel=3 -> stored operand 0x00000000, sel_err=1. Then test err_clr with a coincident bad push -> sel_err stays 1. err_clr alone -> sel_err=0.
- Assert reset asynchronously between edges with count=2 -> out_valid=0, count=0 and in_ready=1 immediately (before the next edge); the first push after deassertion appears normally.
